sd_vedic_mac_ctrl: RTL and testbench
====================================

# sd_vedic_mac_ctrl

Sequencing controller that runs one 4x4 Vedic multiplier (`SD_vedic_4_x_4`) as a streaming multiply-accumulate unit for neural-network dot products. It accepts a job of `len` operand pairs over a valid/ready stream and registers each 8-bit product. It accumulates the products into an `ACC_W`-bit sum and presents the result on a valid/ready output. It sits between the operand-fetch logic and the neuron activation stage.

## Interface
- `ACC_W`, default 16: accumulator and result width, minimum 8.
- `CNT_W`, default 8: width of the job-length field; one job covers at most 2^CNT_W-1 pairs.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: job request; sampled only in IDLE.
- `len`  in  CNT_W: number of operand pairs in the job; sampled with `start`.
- `busy`  out  1: high whenever state is not IDLE.
- `in_valid`  in  1: operand pair on `a`/`b` is valid.
- `in_ready`  out  1: controller accepts a pair this cycle.
- `a`, `b`  in  4 each: unsigned multiplicand and multiplier.
- `out_valid`  out  1: `acc_out` holds the final job result.
- `out_ready`  in  1: downstream consumes the result.
- `acc_out`  out  ACC_W: accumulator register.
- `overflow`  out  1: sticky flag, set if any accumulation carried out of ACC_W bits during the current job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 with `len`!=0: load remaining count with `len`, clear the accumulator, product-valid bit and `overflow`, then go to RUN.
  - `start`=1 with `len`=0: clear the accumulator and `overflow`, then go to DONE. The result is 0.
- RUN: `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) registers `a*b` from the combinational `SD_vedic_4_x_4` instance into an 8-bit product register and sets product-valid.
  - Each handshake decrements the remaining count.
  - The handshake that brings the remaining count to 0 moves the FSM to DRAIN.
  - With no handshake in a cycle, product-valid clears at the next edge.
- Accumulate stage: at every edge where product-valid=1, `acc <= acc + zero_extend(prod)`, taken modulo 2^ACC_W. A carry out of bit ACC_W-1 sets `overflow`.
- DRAIN: `in_ready`=0. The final product is absorbed at this edge, then the FSM goes to DONE.
- DONE:
  - `out_valid`=1; `acc_out` and `overflow` are held stable.
  - `out_ready`=1 returns the FSM to IDLE.
  - The accumulator keeps its value until the next `start`.
- `start` is ignored in RUN, DRAIN and DONE.
- `in_valid` is ignored outside RUN, and `a`/`b` are don't-care when no handshake occurs.
- `rst` asserted in any state, including mid-job, aborts the job and returns to IDLE. The partial sum is discarded.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `in_ready`=0, `out_valid`=0
  - `acc_out`=0, `overflow`=0
  - product register 0, product-valid 0, remaining count 0
- Throughput: one pair per cycle while `in_valid` is held high. Gaps in `in_valid` stall the job without losing pairs.
- Multiply-to-accumulate latency: a pair accepted at edge k is in the product register after edge k and in `acc_out` after edge k+1.
- End of job:
  - Last handshake at edge k makes the FSM DRAIN after edge k, with `in_ready` low in the following cycle.
  - The FSM is DONE after edge k+1, so `out_valid` rises 2 cycles after the last handshake.
- `len`=0: `out_valid` rises 1 cycle after the `start` edge.
- Result handshake: `out_valid` and `acc_out` are held while `out_ready` is low. After the handshake edge, `out_valid`=0 and `busy`=0 in the next cycle.
- Back-to-back jobs: `start` is accepted in the first IDLE cycle after the result handshake.
- All outputs are registered or decoded from the state only; there is no combinational path from inputs to outputs.

## Test plan
- Basic job: `len`=3 with pairs (15,15), (7,9), (2,3) and no bubbles -> `acc_out`=294, `overflow`=0, `out_valid` 2 cycles after the third handshake.
- Stall: the same job with `in_valid` low for 2 cycles between each pair -> `acc_out`=294, with exactly 3 handshakes counted.
- Overflow and wrap, with `ACC_W`=12: `len`=20, all pairs (15,15) -> `acc_out`=404 (4500 mod 4096), `overflow`=1. A following job with `len`=1, (1,1) -> `acc_out`=1, `overflow`=0.
- Zero-length and backpressure: `start` with `len`=0 -> `out_valid` next cycle with `acc_out`=0. With `out_ready` held low for 5 cycles, `out_valid` stays high and `acc_out` stays stable, and a `start` pulse during DONE is ignored.
- Reset mid-job: `len`=4 job, `rst` pulsed after 2 handshakes -> all outputs return to their reset values the next cycle. A new `len`=1 job with (3,5) -> `acc_out`=15.
- Exhaustive product check: `len`=255 job covering the first 255 (a,b) combinations in order -> `acc_out` equals the reference-model sum, `overflow`=0.

Source files
------------

// File: rtl/sd_vedic_mac_ctrl.sv
// ============================================================================
// Module   : sd_vedic_mac_ctrl
// Brief    : Streaming multiply-accumulate controller around a 4x4 Vedic
//            multiplier, used for neural-network dot products.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// 2x2 Urdhva-Tiryagbhyam cell: vertical and crosswise partial products.
module SD_vedic_2_x_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic w_x0;
    logic w_x1;
    logic w_hh;
    logic w_c1;

    assign w_x0 = a[1] & b[0];
    assign w_x1 = a[0] & b[1];
    assign w_hh = a[1] & b[1];
    assign w_c1 = w_x0 & w_x1;

    assign p[0] = a[0] & b[0];
    assign p[1] = w_x0 ^ w_x1;
    assign p[2] = w_hh ^ w_c1;
    assign p[3] = w_hh & w_c1;
endmodule

// 4x4 Vedic multiplier built from four 2x2 cells and a middle-column adder.
module SD_vedic_4_x_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] w_q0;
    logic [3:0] w_q1;
    logic [3:0] w_q2;
    logic [3:0] w_q3;
    logic [5:0] w_mid;
    logic [3:0] w_hi;

    SD_vedic_2_x_2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
    SD_vedic_2_x_2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
    SD_vedic_2_x_2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
    SD_vedic_2_x_2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

    // Cross terms plus the carry-in nibble from the low cell; at most 21.
    assign w_mid = {2'b00, w_q1} + {2'b00, w_q2} + {4'b0000, w_q0[3:2]};
    // A 4x4 product never exceeds 225, so the top nibble cannot carry out.
    assign w_hi  = w_q3 + w_mid[5:2];

    assign p = {w_hi, w_mid[1:0], w_q0[1:0]};
endmodule

module sd_vedic_mac_ctrl #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_prod;
    logic               r_pv;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;

    logic [7:0]         w_prod;
    logic [ACC_W:0]     w_sum;
    logic               w_hs;

    SD_vedic_4_x_4 u_mul (
        .a (a),
        .b (b),
        .p (w_prod)
    );

    assign w_hs  = in_valid && (r_state == RUN);
    // One extra bit on the sum exposes the carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, r_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_pv    <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_pv) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        r_pv  <= 1'b0;
                        if (len != '0) begin
                            r_cnt   <= len;
                            r_state <= RUN;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        r_prod <= w_prod;
                        r_pv   <= 1'b1;
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_pv <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Last product is folded in by the accumulate stage above.
                    r_pv    <= 1'b0;
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign acc_out   = r_acc;
    assign overflow  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_sd_vedic_mac_ctrl.sv
// ============================================================================
// Module   : tb_sd_vedic_mac_ctrl
// Brief    : Self-checking bench; a 16-bit and a 12-bit accumulator instance
//            share stimulus and are checked against an integer-sum model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_vedic_mac_ctrl;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             out_ready;
    logic [3:0]       a;
    logic [3:0]       b;

    logic             busy16, in_ready16, out_valid16, overflow16;
    logic [15:0]      acc16;
    logic             busy12, in_ready12, out_valid12, overflow12;
    logic [11:0]      acc12;

    int errors = 0;
    int checks = 0;

    int pa [0:255];
    int pb [0:255];

    typedef struct {
        int len;
        int mode;     // 0 basic list, 1 constant pair, 2 enumerate, 3 random
        int ca;
        int cb;
        int gap;      // idle cycles before each pair, -1 = random 0..2
        int hold;     // cycles out_ready stays low in DONE
        int exp_sum;  // exact integer sum of products, -1 = from model
    } vec_t;

    vec_t tbl [0:9];

    always #5 clk = ~clk;

    sd_vedic_mac_ctrl #(.ACC_W(16), .CNT_W(CNT_W)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy16),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .a         (a),
        .b         (b),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .acc_out   (acc16),
        .overflow  (overflow16)
    );

    sd_vedic_mac_ctrl #(.ACC_W(12), .CNT_W(CNT_W)) u_dut12 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy12),
        .in_valid  (in_valid),
        .in_ready  (in_ready12),
        .a         (a),
        .b         (b),
        .out_valid (out_valid12),
        .out_ready (out_ready),
        .acc_out   (acc12),
        .overflow  (overflow12)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected accumulator value is the exact sum modulo 2^W; the sticky
    // carry flag is set exactly when the exact sum has reached 2^W.
    task automatic check_all(input string tag, input int eb, input int er,
                             input int eo, input int sum);
        chk({tag, " busy16"},      32'(busy16),      32'(eb));
        chk({tag, " in_ready16"},  32'(in_ready16),  32'(er));
        chk({tag, " out_valid16"}, 32'(out_valid16), 32'(eo));
        chk({tag, " acc16"},       32'(acc16),       32'(sum % 65536));
        chk({tag, " ovf16"},       32'(overflow16),  32'(sum >= 65536));
        chk({tag, " busy12"},      32'(busy12),      32'(eb));
        chk({tag, " in_ready12"},  32'(in_ready12),  32'(er));
        chk({tag, " out_valid12"}, 32'(out_valid12), 32'(eo));
        chk({tag, " acc12"},       32'(acc12),       32'(sum % 4096));
        chk({tag, " ovf12"},       32'(overflow12),  32'(sum >= 4096));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int L, input int gap, input int hold, input int exp_sum);
        int model;
        int fin;
        int applied;
        int pend;
        int g;
        model = 0;
        for (int i = 0; i < L; i++) model += pa[i] * pb[i];
        fin     = (exp_sum >= 0) ? exp_sum : model;
        applied = 0;
        pend    = -1;

        start    = 1'b1;
        len      = CNT_W'(L);
        in_valid = 1'b0;
        step();
        start = 1'b0;
        len   = CNT_W'($urandom);

        if (L == 0) begin
            check_all("len0", 1, 0, 1, 0);
        end else begin
            check_all("run", 1, 1, 0, 0);
            for (int i = 0; i < L; i++) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    a = 4'($urandom);
                    b = 4'($urandom);
                    step();
                    if (pend >= 0) applied += pend;
                    pend = -1;
                    check_all("stall", 1, 1, 0, applied);
                end
                in_valid = 1'b1;
                a = 4'(pa[i]);
                b = 4'(pb[i]);
                step();
                if (pend >= 0) applied += pend;
                pend = pa[i] * pb[i];
                if (i < L - 1) check_all("hs", 1, 1, 0, applied);
                else           check_all("drain", 1, 0, 0, applied);
            end
            // Pair presented during DRAIN must be ignored.
            a = 4'($urandom);
            b = 4'($urandom);
            step();
            in_valid = 1'b0;
            check_all("done", 1, 0, 1, fin);
        end

        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            start     = (k == 1);
            len       = CNT_W'(7);
            in_valid  = 1'b1;
            a = 4'($urandom);
            b = 4'($urandom);
            step();
            start = 1'b0;
            check_all("hold", 1, 0, 1, fin);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_all("idle", 0, 0, 0, fin);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        tbl[0] = '{len: 3,   mode: 0, ca: 0,  cb: 0,  gap: 0, hold: 0, exp_sum: 294};
        tbl[1] = '{len: 3,   mode: 0, ca: 0,  cb: 0,  gap: 2, hold: 0, exp_sum: 294};
        tbl[2] = '{len: 20,  mode: 1, ca: 15, cb: 15, gap: 0, hold: 0, exp_sum: 4500};
        tbl[3] = '{len: 1,   mode: 1, ca: 1,  cb: 1,  gap: 0, hold: 2, exp_sum: 1};
        tbl[4] = '{len: 0,   mode: 1, ca: 0,  cb: 0,  gap: 0, hold: 5, exp_sum: 0};
        tbl[5] = '{len: 255, mode: 2, ca: 0,  cb: 0,  gap: 0, hold: 1, exp_sum: 14175};
        for (int r = 6; r < 10; r++) begin
            tbl[r] = '{len: int'($urandom_range(1, 40)), mode: 3, ca: 0, cb: 0,
                       gap: -1, hold: int'($urandom_range(0, 3)), exp_sum: -1};
        end

        step();
        check_all("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check_all("post_reset", 0, 0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < tbl[r].len; i++) begin
                case (tbl[r].mode)
                    0: begin
                        pa[i] = (i == 0) ? 15 : (i == 1) ? 7 : 2;
                        pb[i] = (i == 0) ? 15 : (i == 1) ? 9 : 3;
                    end
                    1: begin
                        pa[i] = tbl[r].ca;
                        pb[i] = tbl[r].cb;
                    end
                    2: begin
                        pa[i] = i / 16;
                        pb[i] = i % 16;
                    end
                    default: begin
                        pa[i] = int'($urandom_range(0, 15));
                        pb[i] = int'($urandom_range(0, 15));
                    end
                endcase
            end
            run_job(tbl[r].len, tbl[r].gap, tbl[r].hold, tbl[r].exp_sum);
        end

        // Reset in the middle of a job discards the partial sum.
        start    = 1'b1;
        len      = CNT_W'(4);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd9;
        step();
        step();
        in_valid = 1'b0;
        step();
        check_all("pre_rst", 1, 1, 0, 162);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("mid_rst", 0, 0, 0, 0);
        step();
        check_all("after_rst", 0, 0, 0, 0);
        pa[0] = 3;
        pb[0] = 5;
        run_job(1, 0, 0, 15);

        // Back-to-back: start in the first IDLE cycle after the handshake.
        pa[0] = 4;
        pb[0] = 6;
        pa[1] = 10;
        pb[1] = 11;
        run_job(2, 0, 0, 134);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
